conv_output_postproc: RTL and testbench
=======================================

Name: conv_output_postproc

Overview:
- Downstream of the PE-with-buffers stage. Consumes its AXI-Stream of signed 48-bit accumulated conv results (bias already added).
- Per pixel, in order:
  1. adds a scaled per-pixel noise term (StyleGAN noise injection),
  2. applies leaky ReLU,
  3. rounds, shifts and saturates to a signed 16-bit pixel.
- Emits the result as an AXI-Stream for the next layer or DMA.
- Fully pipelined with back-pressure. Checks frame length against tlast.

Parameters:
- RESULT_WIDTH, 48, input accumulator width (signed, FRAC_IN fractional bits)
- PIXEL_WIDTH, 16, output pixel width (signed, FRAC_OUT fractional bits)
- NOISE_WIDTH, 16, width of noise_in and noise_strength (signed Q8.8)
- FRAC_IN, 16, fractional bits of accumulator (Q8.8 pixel × Q8.8 kernel)
- FRAC_OUT, 8, fractional bits of output pixel
- FRAME_PIXELS, 16384, beats per output channel frame (128×128)

Ports:
- clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- s_axis_tdata  in  RESULT_WIDTH  accumulator from PE stage
- s_axis_tvalid  in  1  input beat valid
- s_axis_tlast  in  1  last beat of frame
- s_axis_tready  out  1  input accept
- noise_in  in  NOISE_WIDTH  noise sample for the current input beat; sampled with the beat
- noise_strength  in  NOISE_WIDTH  per-channel noise scale; quasi-static during a frame
- noise_enable  in  1  1 = add noise term, 0 = bypass
- m_axis_tdata  out  PIXEL_WIDTH  output pixel
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  last pixel of frame
- m_axis_tready  in  1  downstream accept
- frame_error  out  1  sticky: tlast misplaced or missing
- postproc_idle  out  1  no beats in flight

Behaviour:
- Pipeline structure
  - Three stages, S1/S2/S3, each with a valid bit; each stage carries tlast alongside its data.
  - S3 registers drive m_axis_* directly.
  - Global advance = !S3_valid || m_axis_tready.
  - s_axis_tready = advance (combinational; no dependency on s_axis_tvalid).
  - Beat accepted when s_axis_tvalid && s_axis_tready.
  - On advance, every stage loads from its predecessor. An empty predecessor loads valid=0.
  - When not advancing, every stage holds. Data and tlast in S3 stay stable while m_axis_tvalid && !m_axis_tready.
- Latency: 3 cycles from accept to m_axis_tvalid with no stall. Throughput is 1 beat/cycle.
- S1 (noise):
  - prod = noise_in × noise_strength, a signed 32-bit Q16.16 value whose fraction matches FRAC_IN.
  - S1 = s_axis_tdata + sign-extend(prod) when noise_enable = 1, else s_axis_tdata. Computed at RESULT_WIDTH; wrap-around cannot occur in range.
- S2 (leaky ReLU):
  - If S1 ≥ 0, S2 = S1.
  - Else S2 = (S1 >>> 3) + (S1 >>> 4), i.e. slope 0.1875 using arithmetic shifts with floor.
- S3 (requantize):
  - Shift by SH = FRAC_IN − FRAC_OUT (default 8).
  - t = (S2 + 2^(SH−1)) >>> SH, i.e. round half up, computed at RESULT_WIDTH+1.
  - Saturate t to [−2^(PIXEL_WIDTH−1), 2^(PIXEL_WIDTH−1)−1] = [0x8000, 0x7FFF].
- Frame check
  - Beat counter runs 0..FRAME_PIXELS−1 and increments per accepted beat.
  - On the beat where count = FRAME_PIXELS−1, or on any beat with s_axis_tlast = 1: counter returns to 0.
  - frame_error is set if tlast = 1 with count ≠ FRAME_PIXELS−1, or tlast = 0 with count = FRAME_PIXELS−1.
  - frame_error stays set until Reset.
  - Output tlast is the delayed input tlast; it is never regenerated.
- postproc_idle = !(S1_valid || S2_valid || S3_valid).
- Reset (synchronous, priority over everything):
  - All valids, counter and frame_error go to 0; m_axis_tdata and m_axis_tlast go to 0.
  - The first cycle after Reset deasserts: s_axis_tready = 1 and postproc_idle = 1.
  - Reset mid-frame discards in-flight beats; no output beat is emitted for them.
- Simultaneous accept and emit in the same cycle is legal and keeps full throughput.

Decomposition:
- Shared package holds:
  - fixed-point constants FRAC_IN, FRAC_OUT, PIXEL_MAX, PIXEL_MIN;
  - leaky shift amounts (3, 4);
  - the default FRAME_PIXELS.
- One natural sub-module, sat_round_shift: combinational round-half-up, arithmetic shift and saturate, parameterised on input width, output width and SH. It is reusable by other layers.

Test Plan:
- Positive, noise off: acc 0x0000_0001_0000 (1.0), m_tready=1 → 0x0100 exactly 3 cycles after accept.
- Negative leaky: acc −0x20000 (−2.0) → 0xFFA0 (−0.375).
- Saturation: acc +200.0 (0xC8_0000) → 0x7FFF; acc −2000.0 (leaky gives −375) → 0x8000.
- Rounding: acc 0x80 → 0x0001; acc 0x7F → 0x0000.
- Noise: acc 0, noise_in 0x0100, noise_strength 0x0080, noise_enable=1 → 0x0080; same beat with noise_enable=0 → 0x0000.
- Back-pressure and framing:
  - Random m_axis_tready and s_axis_tvalid over 2 frames with FRAME_PIXELS=16 → every beat appears in order with none lost or duplicated; output is stable while stalled; tlast appears on beats 15 and 31; frame_error stays 0.
  - tlast injected on beat 9 → frame_error=1 and stays set.
  - Reset mid-frame → postproc_idle=1 next cycle and no further output.

Source files
------------

// File: rtl/conv_output_postproc_pkg.sv
// Shared fixed-point constants for the conv output post-processing stage.
package conv_output_postproc_pkg;
  localparam int FRAC_IN              = 16;
  localparam int FRAC_OUT             = 8;
  localparam int PIXEL_W              = 16;
  localparam logic signed [PIXEL_W-1:0] PIXEL_MAX = 16'sh7FFF;
  localparam logic signed [PIXEL_W-1:0] PIXEL_MIN = 16'sh8000;
  localparam int LEAKY_SH_A           = 3;
  localparam int LEAKY_SH_B           = 4;
  localparam int FRAME_PIXELS_DEFAULT = 16384;
endpackage

// File: rtl/conv_output_postproc_sat_round_shift.sv
// Combinational round-half-up, arithmetic right shift by SH, saturate to OUT_W.
module sat_round_shift #(
  parameter int IN_W  = 48,
  parameter int OUT_W = 16,
  parameter int SH    = 8
) (
  input  logic signed [IN_W-1:0]  din_i,
  output logic signed [OUT_W-1:0] dout_o
);
  localparam logic signed [IN_W:0] HALF  = (IN_W+1)'(1) << (SH-1);
  localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V = ~MAX_V;

  logic signed [IN_W:0] t;

  // One extra bit of headroom so adding HALF to the most positive input cannot wrap.
  always_comb begin
    t = ($signed({din_i[IN_W-1], din_i}) + HALF) >>> SH;
    if (t > MAX_V)      dout_o = MAX_V[OUT_W-1:0];
    else if (t < MIN_V) dout_o = MIN_V[OUT_W-1:0];
    else                dout_o = t[OUT_W-1:0];
  end
endmodule

// File: rtl/conv_output_postproc.sv
// Three-stage AXI-Stream post-processor: noise injection, leaky ReLU, requantise to pixel.
module conv_output_postproc
  import conv_output_postproc_pkg::*;
#(
  parameter int RESULT_WIDTH = 48,
  parameter int PIXEL_WIDTH  = 16,
  parameter int NOISE_WIDTH  = 16,
  parameter int FRAC_IN      = conv_output_postproc_pkg::FRAC_IN,
  parameter int FRAC_OUT     = conv_output_postproc_pkg::FRAC_OUT,
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic [RESULT_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  input  logic [NOISE_WIDTH-1:0]  noise_in,
  input  logic [NOISE_WIDTH-1:0]  noise_strength,
  input  logic                    noise_enable,
  output logic [PIXEL_WIDTH-1:0]  m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    frame_error,
  output logic                    postproc_idle
);
  localparam int SH       = FRAC_IN - FRAC_OUT;
  localparam int PROD_W   = 2 * NOISE_WIDTH;
  localparam int CNT_W    = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIXELS - 1);

  logic                           advance, accept, last_pos;
  logic                           s1_valid_q, s2_valid_q, s3_valid_q;
  logic                           s1_last_q, s2_last_q, s3_last_q;
  logic signed [RESULT_WIDTH-1:0] s1_data_d, s1_data_q, s2_data_d, s2_data_q;
  logic signed [PIXEL_WIDTH-1:0]  s3_data_d, s3_data_q;
  logic signed [PROD_W-1:0]       prod;
  logic signed [RESULT_WIDTH-1:0] noise_term;
  logic [CNT_W-1:0]               cnt_q;
  logic                           frame_err_q;

  assign advance       = !s3_valid_q || m_axis_tready;
  assign accept        = s_axis_tvalid && advance;
  assign last_pos      = (cnt_q == LAST_CNT);
  assign s_axis_tready = advance;

  always_comb begin
    prod       = $signed(noise_in) * $signed(noise_strength);
    noise_term = {{(RESULT_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
    s1_data_d  = $signed(s_axis_tdata) + (noise_enable ? noise_term : '0);
    // Leaky slope 3/16 as two floor shifts, matching the software reference.
    s2_data_d  = s1_data_q[RESULT_WIDTH-1]
               ? (s1_data_q >>> LEAKY_SH_A) + (s1_data_q >>> LEAKY_SH_B)
               : s1_data_q;
  end

  sat_round_shift #(
    .IN_W (RESULT_WIDTH),
    .OUT_W(PIXEL_WIDTH),
    .SH   (SH)
  ) u_sat_round_shift (
    .din_i (s2_data_q),
    .dout_o(s3_data_d)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_last_q   <= 1'b0;
      s3_last_q   <= 1'b0;
      s1_data_q   <= '0;
      s2_data_q   <= '0;
      s3_data_q   <= '0;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      if (advance) begin
        s1_valid_q <= s_axis_tvalid;
        s1_last_q  <= s_axis_tlast;
        s1_data_q  <= s1_data_d;
        s2_valid_q <= s1_valid_q;
        s2_last_q  <= s1_last_q;
        s2_data_q  <= s2_data_d;
        s3_valid_q <= s2_valid_q;
        s3_last_q  <= s2_last_q;
        s3_data_q  <= s3_data_d;
      end
      // Frame length is checked on the input side; output tlast is purely delayed.
      if (accept) begin
        if (s_axis_tlast != last_pos) frame_err_q <= 1'b1;
        cnt_q <= (s_axis_tlast || last_pos) ? '0 : cnt_q + 1'b1;
      end
    end
  end

  assign m_axis_tdata  = s3_data_q;
  assign m_axis_tvalid = s3_valid_q;
  assign m_axis_tlast  = s3_last_q;
  assign frame_error   = frame_err_q;
  assign postproc_idle = !(s1_valid_q || s2_valid_q || s3_valid_q);
endmodule

// File: tb/tb_conv_output_postproc.sv
// Self-checking bench: arithmetic reference model + scoreboard, plus directed literal vectors.
module tb_conv_output_postproc;
  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [47:0] s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [15:0] noise_in = '0, noise_strength = '0;
  logic        noise_enable = 1'b0;
  logic [15:0] m_tdata;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b1;
  logic        frame_error, postproc_idle;

  int checks = 0;
  int errors = 0;
  int emitted = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: never ready

  logic [16:0] exp_q[$];
  bit          stall_prev = 1'b0;
  logic [15:0] prev_data;
  logic        prev_last;

  always #5 clk = ~clk;

  conv_output_postproc #(.FRAME_PIXELS(16)) dut (
    .clk           (clk),
    .Reset         (Reset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .noise_in      (noise_in),
    .noise_strength(noise_strength),
    .noise_enable  (noise_enable),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .frame_error   (frame_error),
    .postproc_idle (postproc_idle)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: plain integer arithmetic on real-valued fixed point.
  function automatic logic [15:0] model_pixel(input longint acc, input longint nz,
                                              input longint st, input bit en);
    longint v, t;
    v = acc;
    if (en) v = v + nz * st;
    if (v < 0) v = fdiv(v, 8) + fdiv(v, 16);
    t = fdiv(v + 128, 256);
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    return t[15:0];
  endfunction

  // Scoreboard and stall-stability checker, sampled mid-cycle.
  always @(negedge clk) begin
    logic [16:0] e;
    if (Reset) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 64'(m_tvalid), 64'd1);
        chk("stall_data", 64'(m_tdata), 64'(prev_data));
        chk("stall_last", 64'(m_tlast), 64'(prev_last));
      end
      if (s_tvalid && s_tready)
        exp_q.push_back({s_tlast, model_pixel(longint'($signed(s_tdata)),
                                              longint'($signed(noise_in)),
                                              longint'($signed(noise_strength)),
                                              noise_enable)});
      if (m_tvalid && m_tready) begin
        emitted++;
        $display("beat %0d: data=%04h last=%0b", emitted, m_tdata, m_tlast);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(m_tdata), 64'hDEAD_0000);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", 64'(m_tdata), 64'(e[15:0]));
          chk("sb_last", 64'(m_tlast), 64'(e[16]));
        end
      end
      stall_prev = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       m_tready = ($urandom_range(0, 1) == 1);
        2:       m_tready = 1'b0;
        default: m_tready = 1'b1;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    s_tvalid = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic push_beat(input logic [47:0] acc, input logic [15:0] nz, input bit en,
                           input bit last);
    int w;
    w = 0;
    s_tdata = acc; noise_in = nz; noise_enable = en; s_tlast = last; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && w < 200) begin
      tick();
      @(negedge clk);
      w++;
    end
    if (!s_tready) chk("accept_timeout", 64'(w), 64'd0);
    tick();
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic send_one(input string nm, input logic [47:0] acc, input logic [15:0] nz,
                          input logic [15:0] st, input bit en, input logic [15:0] req);
    int lat;
    bit got;
    noise_strength = st;
    push_beat(acc, nz, en, 1'b0);
    lat = 1;
    got = 1'b0;
    while (lat < 10 && !got) begin
      @(negedge clk);
      if (m_tvalid) got = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    chk({nm, "_latency"}, 64'(lat), 64'd3);
    chk(nm, 64'(m_tdata), 64'(req));
    tick();
  endtask

  task automatic drain(input string nm);
    int w;
    w = 0;
    ready_mode = 0;
    @(negedge clk);
    while (!postproc_idle && w < 100) begin
      tick();
      @(negedge clk);
      w++;
    end
    chk(nm, 64'(postproc_idle), 64'd1);
    tick();
  endtask

  initial begin
    int base, quiet;
    logic [31:0] u;
    longint r;
    tick();
    @(negedge clk);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    tick();
    Reset = 1'b0;
    @(negedge clk);
    chk("rst_idle", 64'(postproc_idle), 64'd1);
    chk("rst_tready", 64'(s_tready), 64'd1);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_frame_error", 64'(frame_error), 64'd0);
    tick();

    send_one("pos_one", 48'h0000_0001_0000, 16'h0, 16'h0, 1'b0, 16'h0100);
    send_one("neg_leaky", -48'sh20000, 16'h0, 16'h0, 1'b0, 16'hFFA0);
    send_one("sat_pos", 48'h0000_00C8_0000, 16'h0, 16'h0, 1'b0, 16'h7FFF);
    send_one("sat_neg", -48'sh7D0_0000, 16'h0, 16'h0, 1'b0, 16'h8000);
    send_one("round_up", 48'h80, 16'h0, 16'h0, 1'b0, 16'h0001);
    send_one("round_down", 48'h7F, 16'h0, 16'h0, 1'b0, 16'h0000);
    send_one("noise_on", 48'h0, 16'h0100, 16'h0080, 1'b1, 16'h0080);
    send_one("noise_off", 48'h0, 16'h0100, 16'h0080, 1'b0, 16'h0000);

    // Two well-formed frames under random valid/ready.
    do_reset();
    base = emitted;
    noise_strength = 16'h0040;
    ready_mode = 1;
    for (int i = 0; i < 32; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      u = $urandom;
      r = longint'($signed(u)) <<< $urandom_range(0, 5);
      push_beat(r[47:0], 16'($urandom), 1'($urandom), (i % 16) == 15);
    end
    drain("frames_drain");
    chk("frames_count", 64'(emitted - base), 64'd32);
    chk("frames_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("frames_no_error", 64'(frame_error), 64'd0);

    // Early tlast on beat 9 must latch frame_error.
    do_reset();
    for (int i = 0; i < 10; i++) push_beat(48'(i * 256), 16'h0, 1'b0, i == 9);
    drain("early_drain");
    chk("early_tlast_error", 64'(frame_error), 64'd1);
    for (int i = 0; i < 3; i++) push_beat(48'h100, 16'h0, 1'b0, 1'b0);
    drain("sticky_drain");
    chk("error_sticky", 64'(frame_error), 64'd1);

    // Reset with beats stuck in the pipeline discards them.
    ready_mode = 2;
    tick();
    for (int i = 0; i < 3; i++) push_beat(48'h10000, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("midframe_busy", 64'(postproc_idle), 64'd0);
    tick();
    do_reset();
    @(negedge clk);
    chk("midrst_idle", 64'(postproc_idle), 64'd1);
    chk("midrst_tready", 64'(s_tready), 64'd1);
    chk("midrst_error_clr", 64'(frame_error), 64'd0);
    ready_mode = 0;
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      if (m_tvalid) quiet++;
    end
    chk("midrst_no_output", 64'(quiet), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
